syn_fft_but_sched: RTL and testbench
====================================

SYN_FFT_BUT_SCHED -- requirements
Module: syn_fft_but_sched

Interface
REQ-001 Parameter N_LOG2, default 7, log2 of FFT points N (N = 2^N_LOG2; N/2 butterflies per stage, N_LOG2 stages).
REQ-002 Parameter MAX_OUT, default 4, max butterflies issued but not fully written back (1..15).
REQ-003 clk_ir  in  1  sole clock; all logic on rising edge.
REQ-004 rst_il  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  one-cycle pulse; begin a full N-point transform.
REQ-006 busy_o  out  1  high from accepted start until done_o.
REQ-007 done_o  out  1  one-cycle pulse after last write of last stage.
REQ-008 stage_o  out  N_LOG2  current stage index s.
REQ-009 rd_en_o  out  1  sample RAM read strobe (RAM read latency 1 cycle).
REQ-010 rd_addr_a_o / rd_addr_b_o  out  N_LOG2 each  butterfly input addresses.
REQ-011 twdl_addr_o  out  N_LOG2-1  twiddle ROM address, valid with rd_en_o.
REQ-012 but_sample_rdy_o  out  1  drives butterfly sample_rdy.
REQ-013 but_res_rdy_i  in  1  butterfly res_rdy; two pulses per butterfly, result a' then b'.
REQ-014 wr_en_o / wr_addr_o  out  1 / N_LOG2  in-place writeback strobe and address, combinational from but_res_rdy_i.
REQ-015 bffr_ovrflw_i / bffr_underflw_i  in  1 each  butterfly error flags.
REQ-016 err_o  out  3  sticky {proto_err, underflw, ovrflw}.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE: start_i -> ISSUE, clear s, issue index k, write index, outstanding count, err_o; start_i outside IDLE is ignored.
REQ-019 ISSUE: rd_en_o=1 in each cycle with outstanding<MAX_OUT; k increments per issue; outstanding increments per issue.
REQ-020 Addresses for (s,k): half=2^s, pos=k mod half, a=(k>>s)*2*half+pos, b=a+half, twdl=pos<<(N_LOG2-1-s), all unsigned, no wrap.
REQ-021 but_sample_rdy_o asserts exactly one cycle after each rd_en_o cycle.
REQ-022 After issuing k=N/2-1 -> DRAIN; no further rd_en_o until stage complete.
REQ-023 Writeback index j and toggle t track results: t=0 -> wr_addr_o=a(s,j), t=1 -> b(s,j) then j++, outstanding--.
REQ-024 Same-cycle issue and second-result retire leave outstanding unchanged.
REQ-025 DRAIN: outstanding==0 and j==N/2 -> s++, k=j=0 -> ISSUE; if s was N_LOG2-1 -> DONE instead.
REQ-026 DONE: done_o=1 for one cycle, busy_o drops same cycle, -> IDLE.
REQ-027 but_res_rdy_i with outstanding==0 or in IDLE: wr_en_o=0, set err_o[2].
REQ-028 bffr_ovrflw_i / bffr_underflw_i high in any cycle set err_o[0] / err_o[1]; operation continues.
REQ-029 busy_o=1 in ISSUE and DRAIN; 0 in IDLE and DONE.

Reset
REQ-030 rst_il low: immediately IDLE; all outputs, counters, err_o = 0.
REQ-031 Reset mid-transform abandons it; no done_o; next start_i restarts from stage 0.

Verification
REQ-032 N_LOG2=3, butterfly returns 2 res 3 cycles after sample_rdy: stage0 (a,b,tw)=(0,1,0),(2,3,0),(4,5,0),(6,7,0); stage1 k=1 -> (1,3,2); stage2 k=3 -> (3,7,3); 12 issues, 24 writes, one done_o.
REQ-033 MAX_OUT=2, res withheld 20 cycles: exactly 2 rd_en_o pulses then stall; resumes one cycle after 2nd res_rdy of first butterfly.
REQ-034 Stage boundary: last stage-0 write lands before first stage-1 rd_en_o; stage_o steps 0->1 in that gap.
REQ-035 Spurious res_rdy in IDLE -> err_o=3'b100, wr_en_o=0; next start_i clears err_o to 0.
REQ-036 rst_il low mid-stage1 -> outputs 0 same cycle; start_i after release -> first rd_en_o with a=0,b=1,tw=0.
REQ-037 bffr_ovrflw_i pulse during stage 1 -> err_o[0]=1 held through done_o.

Source files
------------

// File: rtl/syn_fft_but_sched.sv
// Butterfly scheduler for an in-place radix-2 FFT: issues sample reads per stage,
// bounds in-flight butterflies and steers the two results of each back to memory.
module syn_fft_but_sched #(
  parameter int N_LOG2  = 7,
  parameter int MAX_OUT = 4
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_LOG2-1:0] stage_o,
  output logic              rd_en_o,
  output logic [N_LOG2-1:0] rd_addr_a_o,
  output logic [N_LOG2-1:0] rd_addr_b_o,
  output logic [N_LOG2-2:0] twdl_addr_o,
  output logic              but_sample_rdy_o,
  input  logic              but_res_rdy_i,
  output logic              wr_en_o,
  output logic [N_LOG2-1:0] wr_addr_o,
  input  logic              bffr_ovrflw_i,
  input  logic              bffr_underflw_i,
  output logic [2:0]        err_o
);

  localparam logic [N_LOG2-1:0] HALF_N  = N_LOG2'(1 << (N_LOG2 - 1));
  localparam logic [N_LOG2-1:0] LAST_K  = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] LAST_S  = N_LOG2'(N_LOG2 - 1);
  localparam logic [3:0]        MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [N_LOG2-1:0] stage_reg, stage_next;
  logic [N_LOG2-1:0] k_reg, k_next;
  logic [N_LOG2-1:0] j_reg, j_next;
  logic              t_reg, t_next;
  logic [3:0]        out_reg, out_next;
  logic [2:0]        err_reg, err_next;
  logic              sample_rdy_reg;

  logic       issue;
  logic       wb_ok;
  logic       retire;
  logic       err_clr;
  logic [2:0] err_set;

  // a = block base (k>>s)*2*half plus position inside the block
  function automatic logic [N_LOG2-1:0] addr_a(input logic [N_LOG2-1:0] s,
                                               input logic [N_LOG2-1:0] k);
    logic [N_LOG2-1:0] half;
    half = N_LOG2'(1) << s;
    return (((k >> s) << s) << 1) | (k & (half - 1'b1));
  endfunction

  function automatic logic [N_LOG2-1:0] addr_b(input logic [N_LOG2-1:0] s,
                                               input logic [N_LOG2-1:0] k);
    return addr_a(s, k) + (N_LOG2'(1) << s);
  endfunction

  function automatic logic [N_LOG2-2:0] addr_tw(input logic [N_LOG2-1:0] s,
                                                input logic [N_LOG2-1:0] k);
    logic [N_LOG2-1:0] pos;
    pos = k & ((N_LOG2'(1) << s) - 1'b1);
    return (N_LOG2-1)'(pos << (LAST_S - s));
  endfunction

  assign issue   = (state_reg == ISSUE) && (out_reg < MAX_CNT);
  assign wb_ok   = but_res_rdy_i && (state_reg != IDLE) && (out_reg != 4'd0);
  assign retire  = wb_ok && t_reg;
  assign err_clr = (state_reg == IDLE) && start_i;
  assign err_set = {but_res_rdy_i && !wb_ok, bffr_underflw_i, bffr_ovrflw_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_err
      assign err_next[gi] = err_clr ? 1'b0 : (err_reg[gi] | err_set[gi]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    k_next     = k_reg;
    j_next     = j_reg;
    t_next     = t_reg;
    out_next   = out_reg + {3'b000, issue} - {3'b000, retire};

    // results retire strictly in issue order: a' then b' of butterfly j
    if (wb_ok) begin
      t_next = ~t_reg;
      if (t_reg) j_next = j_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = ISSUE;
          stage_next = '0;
          k_next     = '0;
          j_next     = '0;
          t_next     = 1'b0;
          out_next   = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          k_next = k_reg + 1'b1;
          if (k_reg == LAST_K) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_reg == 4'd0 && j_reg == HALF_N) begin
          if (stage_reg == LAST_S) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
            stage_next = stage_reg + 1'b1;
            k_next     = '0;
            j_next     = '0;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_reg      <= IDLE;
      stage_reg      <= '0;
      k_reg          <= '0;
      j_reg          <= '0;
      t_reg          <= 1'b0;
      out_reg        <= '0;
      err_reg        <= '0;
      sample_rdy_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      k_reg          <= k_next;
      j_reg          <= j_next;
      t_reg          <= t_next;
      out_reg        <= out_next;
      err_reg        <= err_next;
      sample_rdy_reg <= issue;
    end
  end

  // addresses are zeroed when their strobe is low so idle outputs read as 0
  assign rd_en_o          = issue;
  assign rd_addr_a_o      = issue ? addr_a(stage_reg, k_reg) : '0;
  assign rd_addr_b_o      = issue ? addr_b(stage_reg, k_reg) : '0;
  assign twdl_addr_o      = issue ? addr_tw(stage_reg, k_reg) : '0;
  assign but_sample_rdy_o = sample_rdy_reg;
  assign wr_en_o          = wb_ok;
  assign wr_addr_o        = !wb_ok ? '0 :
                            (t_reg ? addr_b(stage_reg, j_reg) : addr_a(stage_reg, j_reg));
  assign busy_o           = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done_o           = (state_reg == DONE);
  assign stage_o          = stage_reg;
  assign err_o            = err_reg;

endmodule

// File: tb/tb_syn_fft_but_sched.sv
// Directed bench for syn_fft_but_sched with N_LOG2=3, MAX_OUT=2 and a
// behavioural butterfly returning two results a fixed delay after sample_rdy.
module tb_syn_fft_but_sched;

  logic       clk_ir = 1'b0;
  logic       rst_il;
  logic       start_i;
  logic       busy_o, done_o, rd_en_o, but_sample_rdy_o, wr_en_o;
  logic [2:0] stage_o, rd_addr_a_o, rd_addr_b_o, wr_addr_o, err_o;
  logic [1:0] twdl_addr_o;
  logic       but_res_rdy_i, bffr_ovrflw_i, bffr_underflw_i;

  logic       model_res = 1'b0;
  logic       spur;
  logic [21:0] all_out;

  typedef struct { int cyc; int stg; int a; int b; int tw; } ev_t;
  ev_t rd_q[$];
  ev_t wr_q[$];
  int  sr_q[$];
  int  ready_q[$];
  bit  second = 0;

  int cyc = 0;
  int res_delay = 3;
  int done_cnt = 0;
  logic       done_busy;
  logic [2:0] done_err;
  int checks = 0;
  int errors = 0;

  int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  syn_fft_but_sched #(.N_LOG2(3), .MAX_OUT(2)) dut (
    .clk_ir(clk_ir), .rst_il(rst_il), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .stage_o(stage_o),
    .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .twdl_addr_o(twdl_addr_o), .but_sample_rdy_o(but_sample_rdy_o),
    .but_res_rdy_i(but_res_rdy_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .bffr_ovrflw_i(bffr_ovrflw_i), .bffr_underflw_i(bffr_underflw_i), .err_o(err_o)
  );

  assign but_res_rdy_i = model_res | spur;
  assign all_out = {busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o,
                    twdl_addr_o, but_sample_rdy_o, wr_en_o, wr_addr_o, err_o};

  always #5 clk_ir = ~clk_ir;
  always @(posedge clk_ir) cyc <= cyc + 1;

  // butterfly model: results served in order, a' then b', no earlier than res_delay
  always @(posedge clk_ir) begin
    #1;
    if (!rst_il) begin
      ready_q.delete();
      second = 0;
      model_res = 1'b0;
    end else begin
      model_res = 1'b0;
      if (ready_q.size() > 0 && cyc >= ready_q[0]) begin
        model_res = 1'b1;
        if (second) begin
          void'(ready_q.pop_front());
          second = 0;
        end else begin
          second = 1;
        end
      end
      if (but_sample_rdy_o) ready_q.push_back(cyc + res_delay);
    end
  end

  always @(negedge clk_ir) begin
    if (rst_il) begin
      if (rd_en_o)
        rd_q.push_back('{cyc, int'(stage_o), int'(rd_addr_a_o), int'(rd_addr_b_o), int'(twdl_addr_o)});
      if (but_sample_rdy_o) sr_q.push_back(cyc);
      if (wr_en_o) wr_q.push_back('{cyc, int'(stage_o), int'(wr_addr_o), 0, 0});
      if (done_o) begin
        done_cnt++;
        done_busy = busy_o;
        done_err  = err_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    sr_q.delete();
  endtask

  task automatic start_pulse(output int s);
    s = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(done_cnt != base), 32'd1);
  endtask

  task automatic wait_rd(input int cnt, input int limit);
    int n = 0;
    while (rd_q.size() < cnt && n < limit) begin
      tick();
      n++;
    end
    chk("rd_reached", 32'(rd_q.size() >= cnt), 32'd1);
  endtask

  task automatic wait_stage1(input int limit);
    int n = 0;
    while (stage_o != 3'd1 && n < limit) begin
      tick();
      n++;
    end
    chk("stage1_reached", 32'(stage_o), 32'd1);
  endtask

  function automatic int pack4(input int s, input int a, input int b, input int t);
    return (s << 12) | (a << 8) | (b << 4) | t;
  endfunction

  initial begin
    int s;
    int base;
    int exp_w;
    rst_il = 1'b0;
    start_i = 1'b0;
    spur = 1'b0;
    bffr_ovrflw_i = 1'b0;
    bffr_underflw_i = 1'b0;

    repeat (3) tick();
    chk("reset_outputs", 32'(all_out), 32'd0);
    rst_il = 1'b1;
    tick();
    tick();
    chk("idle_outputs", 32'(all_out), 32'd0);

    // spurious result in IDLE
    spur = 1'b1;
    #1;
    chk("spur_wr_en", 32'(wr_en_o), 32'd0);
    tick();
    spur = 1'b0;
    chk("spur_err", 32'(err_o), 32'h4);

    // full transform, result delay 3
    res_delay = 3;
    clear_logs();
    start_pulse(s);
    chk("start_clears_err", 32'(err_o), 32'd0);
    chk("busy_after_start", 32'(busy_o), 32'd1);
    wait_done(0, 2000);
    chk("issue_count", 32'(rd_q.size()), 32'd12);
    chk("write_count", 32'(wr_q.size()), 32'd24);
    chk("sample_rdy_count", 32'(sr_q.size()), 32'd12);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_at_done", 32'(done_busy), 32'd0);
    chk("first_issue_latency", 32'(rd_q[0].cyc), 32'(s + 1));
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("issue_%0d", i),
          32'(pack4(rd_q[i].stg, rd_q[i].a, rd_q[i].b, rd_q[i].tw)),
          32'(pack4(i / 4, exp_a[i], exp_b[i], exp_tw[i])));
      chk($sformatf("sample_rdy_%0d", i), 32'(sr_q[i]), 32'(rd_q[i].cyc + 1));
    end
    for (int i = 0; i < 24; i++) begin
      exp_w = (i % 2 == 1) ? exp_b[i / 2] : exp_a[i / 2];
      chk($sformatf("write_%0d", i), 32'(pack4(wr_q[i].stg, wr_q[i].a, 0, 0)),
          32'(pack4(i / 8, exp_w, 0, 0)));
    end
    chk("boundary_order", 32'(rd_q[4].cyc > wr_q[7].cyc), 32'd1);
    chk("boundary_last_s0_write_stage", 32'(wr_q[7].stg), 32'd0);
    chk("boundary_first_s1_issue_stage", 32'(rd_q[4].stg), 32'd1);
    chk("idle_after_done", 32'(busy_o), 32'd0);
    chk("err_clean", 32'(err_o), 32'd0);

    // outstanding limit with withheld results, plus overflow during stage 1
    res_delay = 20;
    tick();
    clear_logs();
    start_pulse(s);
    wait_rd(3, 200);
    chk("stall_rd0", 32'(rd_q[0].cyc), 32'(s + 1));
    chk("stall_rd1", 32'(rd_q[1].cyc), 32'(s + 2));
    chk("stall_second_res", 32'(wr_q[1].cyc), 32'(s + 23));
    chk("stall_resume", 32'(rd_q[2].cyc), 32'(s + 24));
    wait_stage1(600);
    bffr_ovrflw_i = 1'b1;
    tick();
    bffr_ovrflw_i = 1'b0;
    chk("ovf_err", 32'(err_o), 32'h1);
    wait_done(1, 2000);
    chk("ovf_err_at_done", 32'(done_err), 32'h1);
    chk("done_count_2", 32'(done_cnt), 32'd2);

    // reset mid stage 1, then restart
    res_delay = 3;
    tick();
    clear_logs();
    start_pulse(s);
    wait_stage1(300);
    tick();
    tick();
    rst_il = 1'b0;
    #1;
    chk("abort_outputs", 32'(all_out), 32'd0);
    repeat (3) tick();
    rst_il = 1'b1;
    base = done_cnt;
    repeat (5) tick();
    chk("no_done_after_abort", 32'(done_cnt), 32'(base));
    chk("idle_after_abort", 32'(busy_o), 32'd0);
    clear_logs();
    start_pulse(s);
    wait_rd(1, 20);
    chk("restart_first_issue", 32'(pack4(rd_q[0].stg, rd_q[0].a, rd_q[0].b, rd_q[0].tw)),
        32'(pack4(0, 0, 1, 0)));
    wait_done(base, 2000);
    chk("restart_done_count", 32'(done_cnt), 32'(base + 1));

    // underflow while idle
    tick();
    bffr_underflw_i = 1'b1;
    tick();
    bffr_underflw_i = 1'b0;
    chk("udf_err", 32'(err_o), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
